test_status_device: RTL and testbench



---
 rtl/test_status_pkg.sv | 19 +
 rtl/test_status_device_if.sv | 12 +
 rtl/test_status_device_sync_fifo.sv | 56 +++++
 rtl/test_status_device.sv | 128 ++++++++++++
 tb/tb_test_status_device.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/test_status_pkg.sv
// Shared definitions for the test status device: register offsets, state encoding
// and the tohost pass token.
package test_status_pkg;

   typedef enum logic [1:0] {
      RUNNING = 2'd0,
      PASSED  = 2'd1,
      FAILED  = 2'd2,
      TIMEOUT = 2'd3
   } test_state_t;

   localparam logic [1:0] REG_STATUS  = 2'd0;
   localparam logic [1:0] REG_CONSOLE = 2'd1;
   localparam logic [1:0] REG_FLAGS   = 2'd2;
   localparam logic [1:0] REG_CYCLES  = 2'd3;

   localparam logic [31:0] TOHOST_PASS = 32'h1;

endpackage

// File: rtl/test_status_device_if.sv
// Core data-bus slice seen by the test status device: address, write data,
// strobes and combinational read data.
interface test_status_device_if;
   logic [31:0] a;
   logic [31:0] wd;
   logic        we;
   logic        re;
   logic [31:0] rd;

   modport master (output a, output wd, output we, output re, input rd);
   modport slave  (input a, input wd, input we, input re, output rd);
endinterface

// File: rtl/test_status_device_sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted only when a pop frees
// a slot in the same cycle, otherwise it is dropped and flagged for one cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     dropped
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dropped = push && !do_push;
   assign count   = count_reg;
   assign head    = mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         count_reg <= count_reg + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
   end
endmodule

// File: rtl/test_status_device.sv
// Memory-mapped test outcome responder: latches the core's PASS/FAIL report,
// queues console bytes and times out a run that never reports.
module test_status_device
   import test_status_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR      = 32'hFFFF_FF00,
   parameter int          FIFO_DEPTH     = 16,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic                 clk,
   input  logic                 reset,
   test_status_device_if.slave  bus,
   output logic [7:0]           tx_data,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   output logic                 done,
   output logic                 pass,
   output logic [30:0]          fail_code,
   output logic                 timeout,
   output logic                 overflow
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   test_state_t       state_reg;
   test_state_t       state_next;
   logic [30:0]       fail_code_reg;
   logic [30:0]       fail_code_next;
   logic [31:0]       cycles_reg;
   logic              overflow_reg;

   logic              sel;
   logic [1:0]        offset;
   logic              wr_status;
   logic              wr_console;
   logic              watchdog_hit;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_dropped;
   logic [CNT_W-1:0]  fifo_count;
   logic [31:0]       flags_word;
   logic              unused_addr_bits;

   assign sel        = (bus.a[31:4] == BASE_ADDR[31:4]);
   assign offset     = bus.a[3:2];
   assign wr_status  = sel && bus.we && (offset == REG_STATUS);
   assign wr_console = sel && bus.we && (offset == REG_CONSOLE);
   assign unused_addr_bits = &{1'b0, bus.a[1:0]};

   // The counter itself is the watchdog: it only advances while RUNNING.
   assign watchdog_hit = (TIMEOUT_CYCLES != 0) && (cycles_reg == 32'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_next     = state_reg;
      fail_code_next = fail_code_reg;
      if (state_reg == RUNNING) begin
         if (wr_status && (bus.wd == TOHOST_PASS)) begin
            state_next = PASSED;
         end else if (wr_status && bus.wd[0]) begin
            state_next     = FAILED;
            fail_code_next = bus.wd[31:1];
         end else if (watchdog_hit) begin
            state_next = TIMEOUT;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= RUNNING;
         fail_code_reg <= '0;
         cycles_reg    <= '0;
         overflow_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         fail_code_reg <= fail_code_next;
         if (state_reg == RUNNING) begin
            cycles_reg <= cycles_reg + 32'd1;
         end
         if (fifo_dropped) begin
            overflow_reg <= 1'b1;
         end
      end
   end

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_console_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (wr_console),
      .push_data (bus.wd[7:0]),
      .pop       (tx_valid && tx_ready),
      .head      (tx_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count),
      .dropped   (fifo_dropped)
   );

   assign tx_valid  = !fifo_empty;
   assign done      = (state_reg != RUNNING);
   assign pass      = (state_reg == PASSED);
   assign timeout   = (state_reg == TIMEOUT);
   assign fail_code = fail_code_reg;
   assign overflow  = overflow_reg;

   always_comb begin
      flags_word              = '0;
      flags_word[8 +: CNT_W]  = fifo_count;
      flags_word[3]           = overflow_reg;
      flags_word[2]           = timeout;
      flags_word[1]           = fifo_full;
      flags_word[0]           = fifo_empty;
   end

   always_comb begin
      bus.rd = '0;
      if (sel && bus.re) begin
         case (offset)
            REG_STATUS:  bus.rd = {fail_code_reg, pass};
            REG_FLAGS:   bus.rd = flags_word;
            REG_CYCLES:  bus.rd = cycles_reg;
            default:     bus.rd = '0;
         endcase
      end
   end
endmodule

// File: tb/tb_test_status_device.sv
// Directed bench for test_status_device with a 4-entry FIFO and a 20-cycle watchdog.
module tb_test_status_device;
   localparam logic [31:0] BASE     = 32'hFFFF_FF00;
   localparam logic [31:0] A_STATUS = BASE + 32'h0;
   localparam logic [31:0] A_CONS   = BASE + 32'h4;
   localparam logic [31:0] A_FLAGS  = BASE + 32'h8;
   localparam logic [31:0] A_CYC    = BASE + 32'hC;

   logic        clk;
   logic        reset;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        done;
   logic        pass;
   logic [30:0] fail_code;
   logic        timeout;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   test_status_device_if bus ();

   test_status_device #(
      .BASE_ADDR      (BASE),
      .FIFO_DEPTH     (4),
      .TIMEOUT_CYCLES (20)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .done      (done),
      .pass      (pass),
      .fail_code (fail_code),
      .timeout   (timeout),
      .overflow  (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end else begin
         $display("ok   %s = %h", tag, got);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      bus.we   = 1'b0;
      bus.re   = 1'b0;
      tx_ready = 1'b0;
      tick(1);
      reset = 1'b0;
   endtask

   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
      bus.a  = addr;
      bus.wd = data;
      bus.we = 1'b1;
      tick(1);
      bus.we = 1'b0;
      $display("write a=%h wd=%h", addr, data);
   endtask

   task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
      bus.a  = addr;
      bus.re = 1'b1;
      #1;
      data   = bus.rd;
      bus.re = 1'b0;
   endtask

   logic [31:0] r;
   logic [7:0]  hello [5];
   logic [7:0]  exp5 [4];

   initial begin
      reset = 1'b1; tx_ready = 1'b0;
      bus.a = '0; bus.wd = '0; bus.we = 1'b0; bus.re = 1'b0;
      hello[0] = "H"; hello[1] = "e"; hello[2] = "l"; hello[3] = "l"; hello[4] = "o";
      exp5[0] = "B"; exp5[1] = "C"; exp5[2] = "D"; exp5[3] = "X";

      // 1: reset state and PASS
      do_reset();
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_pass", 32'(pass), 32'd0);
      check_eq("rst_timeout", 32'(timeout), 32'd0);
      check_eq("rst_overflow", 32'(overflow), 32'd0);
      check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
      bus_read(A_FLAGS, r);  check_eq("rst_flags", r, 32'h1);
      bus_read(A_CYC, r);    check_eq("rst_cycles", r, 32'd0);
      bus_write(A_STATUS, 32'h1);
      check_eq("t1_done", 32'(done), 32'd1);
      check_eq("t1_pass", 32'(pass), 32'd1);
      check_eq("t1_fail_code", 32'(fail_code), 32'd0);
      bus_read(A_CYC, r);    check_eq("t1_cycles", r, 32'd1);
      tick(3);
      bus_read(A_CYC, r);    check_eq("t1_cycles_frozen", r, 32'd1);
      bus_read(A_STATUS, r); check_eq("t1_status_rd", r, 32'h1);
      bus.a = A_CYC; #1;     check_eq("t1_rd_re_low", bus.rd, 32'd0);

      // 2: ignored writes, then FAIL with a[1:0] set
      do_reset();
      bus_write(A_STATUS, 32'h2);
      check_eq("t2_even_ignored", 32'(done), 32'd0);
      bus_write(32'hFFFF_FE00, 32'h1);
      check_eq("t2_unsel_ignored", 32'(done), 32'd0);
      bus_write(A_STATUS | 32'h3, 32'h7);
      check_eq("t2_done", 32'(done), 32'd1);
      check_eq("t2_pass", 32'(pass), 32'd0);
      check_eq("t2_fail_code", 32'(fail_code), 32'd3);
      bus_write(A_STATUS, 32'h1);
      check_eq("t2_pass_after", 32'(pass), 32'd0);
      check_eq("t2_fail_code_after", 32'(fail_code), 32'd3);
      bus_read(A_STATUS, r); check_eq("t2_status_rd", r, 32'h6);
      bus.a = 32'h0000_0000; bus.re = 1'b1; #1;
      check_eq("t2_unsel_rd", bus.rd, 32'd0);
      bus.re = 1'b0;

      // 3a: watchdog fires 20 cycles after reset falls
      do_reset();
      tick(19);
      check_eq("t3_no_timeout_19", 32'(timeout), 32'd0);
      tick(1);
      check_eq("t3_timeout_20", 32'(timeout), 32'd1);
      check_eq("t3_done", 32'(done), 32'd1);
      bus_read(A_CYC, r);    check_eq("t3_cycles", r, 32'd20);
      bus_read(A_FLAGS, r);  check_eq("t3_flags", r, 32'h5);
      bus_write(A_STATUS, 32'h1);
      check_eq("t3_pass_ignored", 32'(pass), 32'd0);
      bus_write(A_CONS, 32'h5A);
      check_eq("t3_cons_tx_valid", 32'(tx_valid), 32'd1);
      check_eq("t3_cons_tx_data", 32'(tx_data), 32'h5A);

      // 3b: STATUS write on the watchdog cycle wins
      do_reset();
      tick(19);
      bus_write(A_STATUS, 32'h1);
      check_eq("t3b_pass", 32'(pass), 32'd1);
      check_eq("t3b_timeout", 32'(timeout), 32'd0);

      // 4: overflow on a full FIFO, then in-order drain
      do_reset();
      for (int i = 0; i < 5; i++) bus_write(A_CONS, 32'(hello[i]));
      bus_read(A_FLAGS, r);  check_eq("t4_flags", r, 32'h40A);
      check_eq("t4_overflow", 32'(overflow), 32'd1);
      bus_read(A_CONS, r);   check_eq("t4_console_rd", r, 32'd0);
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check_eq("t4_pop_data", 32'(tx_data), 32'(hello[i]));
         tick(1);
      end
      check_eq("t4_drained", 32'(tx_valid), 32'd0);
      tx_ready = 1'b0;

      // 6: reset mid-run with bytes queued and FAILED
      for (int i = 0; i < 3; i++) bus_write(A_CONS, 32'h30 + 32'(i));
      bus_write(A_STATUS, 32'h5);
      check_eq("t6_failed", 32'(fail_code), 32'd2);
      check_eq("t6_tx_valid_pre", 32'(tx_valid), 32'd1);
      do_reset();
      check_eq("t6_done", 32'(done), 32'd0);
      check_eq("t6_fail_code", 32'(fail_code), 32'd0);
      check_eq("t6_overflow", 32'(overflow), 32'd0);
      check_eq("t6_tx_valid", 32'(tx_valid), 32'd0);
      bus_read(A_FLAGS, r);  check_eq("t6_flags", r, 32'h1);
      bus_read(A_CYC, r);    check_eq("t6_cycles", r, 32'd0);

      // 5: push and pop together on a full FIFO
      do_reset();
      for (int i = 0; i < 4; i++) bus_write(A_CONS, 32'h41 + 32'(i));
      tx_ready = 1'b1;
      bus_write(A_CONS, 32'h58);
      tx_ready = 1'b0;
      bus_read(A_FLAGS, r);  check_eq("t5_flags", r, 32'h402);
      check_eq("t5_overflow", 32'(overflow), 32'd0);
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check_eq("t5_pop_data", 32'(tx_data), 32'(exp5[i]));
         tick(1);
      end
      check_eq("t5_drained", 32'(tx_valid), 32'd0);
      tx_ready = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL sim_time_limit got=expired exp=finished");
      $fatal(1, "time limit");
   end
endmodule
